// File: rtl/regfile_nport.sv
// regfile_nport: 2^ADDR_W x DATA_W register file with one-hot write decoder, two read ports,
// optional hardwired-zero r0, same-cycle write bypass and a written-since-reset bitmap.
module regfile_nport #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int NREG    = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              regWrite,
    input  logic [ADDR_W-1:0] destReg,
    input  logic [DATA_W-1:0] writeData,
    input  logic [ADDR_W-1:0] srcReg1,
    input  logic [ADDR_W-1:0] srcReg2,
    output logic [DATA_W-1:0] readData1,
    output logic [DATA_W-1:0] readData2,
    output logic [NREG-1:0]   decOut,
    output logic [NREG-1:0]   written
);
    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   wen;
    logic              byp1, byp2;

    always_comb begin
        decOut          = '0;
        decOut[destReg] = regWrite;
    end

    // r0 stays decoded but never stored when hardwired to zero
    assign wen = decOut & {{(NREG-1){1'b1}}, ZERO_REG == 0};

    // bypass is gated by reset so reads stay zero while reset is held
    assign byp1 = BYPASS != 0 && reset && regWrite && srcReg1 == destReg;
    assign byp2 = BYPASS != 0 && reset && regWrite && srcReg2 == destReg;

    assign readData1 = (ZERO_REG != 0 && srcReg1 == '0) ? '0 : byp1 ? writeData : regs[srcReg1];
    assign readData2 = (ZERO_REG != 0 && srcReg2 == '0) ? '0 : byp2 ? writeData : regs[srcReg2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            written <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) if (wen[i]) regs[i] <= writeData;
            written <= written | wen;
        end
    end
endmodule

// File: tb/tb_regfile_nport.sv
// tb_regfile_nport: directed checks on two instances, one with zero-reg and bypass, one without.
module tb_regfile_nport;
    logic        clk = 0;
    logic        reset = 0;
    logic        regWrite = 0;
    logic [3:0]  destReg = 0, srcReg1 = 0, srcReg2 = 0;
    logic [31:0] writeData = 0;
    logic [31:0] rd1a, rd2a, rd1b, rd2b;
    logic [15:0] deca, decb, wra, wrb;
    int passed = 0, total = 0;

    always #5 clk = ~clk;

    regfile_nport u_a (
        .clk(clk), .reset(reset), .regWrite(regWrite), .destReg(destReg), .writeData(writeData),
        .srcReg1(srcReg1), .srcReg2(srcReg2), .readData1(rd1a), .readData2(rd2a),
        .decOut(deca), .written(wra)
    );

    regfile_nport #(.ZERO_REG(0), .BYPASS(0)) u_b (
        .clk(clk), .reset(reset), .regWrite(regWrite), .destReg(destReg), .writeData(writeData),
        .srcReg1(srcReg1), .srcReg2(srcReg2), .readData1(rd1b), .readData2(rd2b),
        .decOut(decb), .written(wrb)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        for (int a = 0; a < 16; a++) begin
            srcReg1 = 4'(a);
            srcReg2 = 4'(a);
            #1;
            chk("rst_rd1a", rd1a, 0);
            chk("rst_rd2a", rd2a, 0);
            chk("rst_rd1b", rd1b, 0);
            chk("rst_rd2b", rd2b, 0);
        end
        chk("rst_wra", 32'(wra), 0);
        chk("rst_wrb", 32'(wrb), 0);
        reset = 1;
        tick();

        regWrite = 1; destReg = 5; writeData = 32'hDEADBEEF; srcReg1 = 5; srcReg2 = 1;
        #1;
        chk("byp_rd1a", rd1a, 32'hDEADBEEF);
        chk("nobyp_rd1b_pre", rd1b, 0);
        chk("dec5_a", 32'(deca), 32'h0020);
        chk("dec5_b", 32'(decb), 32'h0020);
        tick();
        regWrite = 0;
        #1;
        chk("post_rd1a", rd1a, 32'hDEADBEEF);
        chk("post_rd1b", rd1b, 32'hDEADBEEF);
        chk("wr5_a", 32'(wra), 32'h0020);
        chk("wr5_b", 32'(wrb), 32'h0020);

        regWrite = 1; destReg = 0; writeData = 32'h1234; srcReg1 = 0; srcReg2 = 0;
        #1;
        chk("dec0_a", 32'(deca), 32'h0001);
        chk("zero_byp_rd1a", rd1a, 0);
        chk("zero_byp_rd2a", rd2a, 0);
        tick();
        regWrite = 0;
        #1;
        chk("zero_rd1a", rd1a, 0);
        chk("zero_rd2a", rd2a, 0);
        chk("zero_wra", 32'(wra), 32'h0020);
        chk("r0_rd1b", rd1b, 32'h1234);
        chk("r0_wrb", 32'(wrb), 32'h0021);

        for (int i = 0; i < 16; i++) begin
            regWrite = 1; destReg = 4'(i); writeData = 32'h100 + 32'(i);
            tick();
        end
        regWrite = 0;
        #1;
        chk("dec_idle_a", 32'(deca), 0);
        chk("dec_idle_b", 32'(decb), 0);
        chk("sweep_wra", 32'(wra), 32'hFFFE);
        chk("sweep_wrb", 32'(wrb), 32'hFFFF);
        for (int i = 0; i < 16; i++) begin
            srcReg1 = 4'(i);
            srcReg2 = 4'(15 - i);
            #1;
            chk("sweep_rd1a", rd1a, i == 0 ? 32'h0 : 32'h100 + 32'(i));
            chk("sweep_rd2a", rd2a, i == 15 ? 32'h0 : 32'h100 + 32'(15 - i));
            chk("sweep_rd1b", rd1b, 32'h100 + 32'(i));
            chk("sweep_rd2b", rd2b, 32'h100 + 32'(15 - i));
        end

        regWrite = 1; destReg = 3; writeData = 32'hCAFE; srcReg1 = 3; srcReg2 = 3;
        #1;
        chk("dual_byp_rd1a", rd1a, 32'hCAFE);
        chk("dual_byp_rd2a", rd2a, 32'hCAFE);
        chk("dual_rd1b", rd1b, 32'h103);
        chk("dual_rd2b", rd2b, 32'h103);
        regWrite = 0;
        #1;
        chk("dual_drop_rd1a", rd1a, 32'h103);

        tick();
        regWrite = 1; destReg = 7; writeData = 32'hAA;
        tick();
        regWrite = 0; srcReg1 = 7; srcReg2 = 5;
        #1;
        chk("r7_rd1a", rd1a, 32'hAA);
        #2;
        reset = 0;
        #1;
        chk("async_rd1a", rd1a, 0);
        chk("async_rd1b", rd1b, 0);
        chk("async_rd2b", rd2b, 0);
        chk("async_wra", 32'(wra), 0);
        chk("async_wrb", 32'(wrb), 0);
        regWrite = 1; destReg = 9; writeData = 32'h55; srcReg1 = 9;
        tick();
        tick();
        regWrite = 0;
        chk("rstwr_wrb", 32'(wrb), 0);
        reset = 1;
        #1;
        chk("rstwr_rd1a", rd1a, 0);
        chk("rstwr_rd1b", rd1b, 0);
        regWrite = 1;
        tick();
        regWrite = 0;
        #1;
        chk("after_rd1b", rd1b, 32'h55);
        chk("after_wrb", 32'(wrb), 32'h0200);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
